gumnut_gpr_writeback: RTL

Register-file and write-back stage around the Gumnut ALU. It supplies the combinational GPR_rs/GPR_r2 operands to the ALU and holds the condition-code flags cc_C/cc_Z, which are fed back to the ALU's carry-in. It retires each executed instruction by writing the ALU result or load data to rd and updating the flags. Loads wait on a memory/IO acknowledge handshake before they retire.

---
 rtl/gumnut_pkg.sv | 51 +++++
 rtl/gumnut_regfile.sv | 48 ++++
 rtl/gumnut_gpr_writeback.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gumnut_pkg.sv
// Shared Gumnut definitions: instruction field positions, opcode-class
// prefixes, memory function codes and the write-back FSM states.
package gumnut_pkg;

    localparam int GPR_W    = 8;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;
    localparam int IR_W     = 18;

    // Instruction field bit positions
    localparam int RD_MSB    = 13;
    localparam int RD_LSB    = 11;
    localparam int RS_MSB    = 10;
    localparam int RS_LSB    = 8;
    localparam int R2_MSB    = 7;
    localparam int R2_LSB    = 5;
    localparam int MEMFN_MSB = 15;
    localparam int MEMFN_LSB = 14;

    // Opcode-class prefixes, compared against the top bits of IR
    localparam logic       CLS_ALU_IMMED = 1'b0;
    localparam logic [1:0] CLS_MEM       = 2'b10;
    localparam logic [2:0] CLS_SHIFT     = 3'b110;
    localparam logic [3:0] CLS_ALU_REG   = 4'b1110;

    // Memory / IO function codes
    localparam logic [1:0] MEM_LDM = 2'b00;
    localparam logic [1:0] MEM_STM = 2'b01;
    localparam logic [1:0] MEM_INP = 2'b10;
    localparam logic [1:0] MEM_OUT = 2'b11;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    // True for instructions that retire an ALU/shift result in one cycle
    function automatic logic is_alu_writeback(input logic [IR_W-1:0] ir);
        return (ir[17] == CLS_ALU_IMMED)
            || (ir[17:15] == CLS_SHIFT)
            || (ir[17:14] == CLS_ALU_REG);
    endfunction

    // True for ldm/inp, which retire only after the memory acknowledge
    function automatic logic is_load(input logic [IR_W-1:0] ir);
        return (ir[17:16] == CLS_MEM)
            && ((ir[MEMFN_MSB:MEMFN_LSB] == MEM_LDM)
             || (ir[MEMFN_MSB:MEMFN_LSB] == MEM_INP));
    endfunction

endpackage

// File: rtl/gumnut_regfile.sv
// Gumnut general-purpose register file: r0 hard-wired to zero, two
// asynchronous read ports and one synchronous write port.
module gumnut_regfile
    import gumnut_pkg::*;
#(
    parameter int DATA_W = GPR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next register contents: apply the single write, never disturb r0
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Register storage, cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports show the pre-edge value; r0 always reads zero
    always_comb begin
        rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
        rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
    end

endmodule

// File: rtl/gumnut_gpr_writeback.sv
// Gumnut register-file and write-back stage: supplies ALU operands, holds
// the C/Z flags and retires ALU results or load data into rd.
module gumnut_gpr_writeback
    import gumnut_pkg::*;
#(
    parameter int DATA_W = GPR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IR_W-1:0]   IR,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              ALU_carry,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] GPR_rs,
    output logic [DATA_W-1:0] GPR_r2,
    output logic              cc_C,
    output logic              cc_Z,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr
);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] load_rd_q, load_rd_d;
    logic              cc_c_q, cc_c_d;
    logic              cc_z_q, cc_z_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] wb_addr_q, wb_addr_d;

    logic              accept;
    logic              alu_retire;
    logic              load_start;
    logic              load_done;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              ir_unused;

    // Immediate/offset bits below r2 are consumed by the ALU, not here
    assign ir_unused = ^IR[R2_LSB-1:0];

    gumnut_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (IR[RS_MSB:RS_LSB]),
        .raddr_b (IR[R2_MSB:R2_LSB]),
        .rdata_a (GPR_rs),
        .rdata_b (GPR_r2)
    );

    // Handshake and retire decisions; ALU retire and load completion are exclusive
    always_comb begin
        ex_ready   = (state_q == IDLE);
        accept     = ex_valid && ex_ready;
        alu_retire = accept && is_alu_writeback(IR);
        load_start = accept && is_load(IR);
        load_done  = (state_q == LOAD_WAIT) && mem_ack;
        rf_we      = alu_retire || load_done;
        rf_waddr   = load_done ? load_rd_q : IR[RD_MSB:RD_LSB];
        rf_wdata   = load_done ? mem_data : ALU_result;
    end

    // Next-state for FSM, captured load target, flags and write-back report
    always_comb begin
        state_d   = state_q;
        load_rd_d = load_rd_q;
        cc_c_d    = cc_c_q;
        cc_z_d    = cc_z_q;
        wb_en_d   = rf_we;
        wb_addr_d = rf_we ? rf_waddr : wb_addr_q;
        case (state_q)
            IDLE: begin
                if (alu_retire) begin
                    cc_c_d = ALU_carry;
                    cc_z_d = (ALU_result == '0);
                end
                if (load_start) begin
                    state_d   = LOAD_WAIT;
                    load_rd_d = IR[RD_MSB:RD_LSB];
                end
            end
            LOAD_WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            load_rd_q <= '0;
            cc_c_q    <= 1'b0;
            cc_z_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            load_rd_q <= load_rd_d;
            cc_c_q    <= cc_c_d;
            cc_z_q    <= cc_z_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
        end
    end

    assign cc_C    = cc_c_q;
    assign cc_Z    = cc_z_q;
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;

endmodule
